// File: rtl/lsu_mem_access_pkg.sv
// Shared types for the load/store unit: memory-op encoding, size decode, exception causes, FSM states.
package lsu_mem_access_pkg;

   // [3]=load, [2:1]=size (11 byte, 01 half, 10 word, 00 none), [0]=unsigned
   typedef enum logic [3:0] {
      MEM_NOP = 4'b0000,
      MEM_SW  = 4'b0100,
      MEM_SH  = 4'b0010,
      MEM_SB  = 4'b0110,
      MEM_LW  = 4'b1100,
      MEM_LH  = 4'b1010,
      MEM_LHU = 4'b1011,
      MEM_LB  = 4'b1110,
      MEM_LBU = 4'b1111
   } mem_inst_type_t;

   typedef enum logic [1:0] {
      SIZE_NONE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_BYTE = 2'b11
   } mem_size_e;

   typedef enum logic [1:0] {
      LSU_IDLE,
      LSU_REQ,
      LSU_WAIT_RSP,
      LSU_DONE
   } lsu_state_e;

   localparam logic [31:0] CAUSE_LOAD_MISALIGN  = 32'd4;
   localparam logic [31:0] CAUSE_LOAD_FAULT     = 32'd5;
   localparam logic [31:0] CAUSE_STORE_MISALIGN = 32'd6;
   localparam logic [31:0] CAUSE_STORE_FAULT    = 32'd7;

   function automatic mem_size_e mem_size(input logic [3:0] mem_type);
      return mem_size_e'(mem_type[2:1]);
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load return path: picks the addressed byte/half lane out of the bus word and sign- or zero-extends it.
module lsu_load_align
   import lsu_mem_access_pkg::*;
(
   input  logic [31:0] bus_rdata,
   input  logic [1:0]  byte_off,
   input  mem_size_e   size,
   input  logic        is_unsigned,
   output logic [31:0] load_data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
   always_comb begin
      byte_lane = bus_rdata[{byte_off, 3'b000} +: 8];
      half_lane = byte_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      load_data = bus_rdata;
      case (size)
         SIZE_BYTE: load_data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
         SIZE_HALF: load_data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
         default:   load_data = bus_rdata;
      endcase
   end

endmodule

// File: rtl/lsu_mem_access.sv
// MEM_OP-stage load/store unit: one req/gnt/rvalid bus transaction per start_i, with misalign/timeout exceptions.
// Build option MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of forcing them to alignment.
module lsu_mem_access
   import lsu_mem_access_pkg::*;
#(
   parameter int unsigned BUS_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [3:0]  mem_type_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] rdata_o,
   output logic        exc_o,
   output logic [31:0] exc_cause_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_gnt_i,
   input  logic        bus_rvalid_i,
   input  logic [31:0] bus_rdata_i
);

   localparam int unsigned    CNT_W    = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);

   lsu_state_e        state_q, state_d;
   mem_size_e         size_s, size_q;
   logic [1:0]        off_s, off_q;
   logic              access_s, trap_s, timeout_hit;
   logic [3:0]        be_s, be_q;
   logic [31:0]       wdata_s, wdata_q;
   logic [29:0]       addr_q;
   logic [31:0]       rdata_q, cause_q, load_data;
   logic              we_q, uns_q, exc_q;
   logic [CNT_W-1:0]  cnt_q;

   // Decode of the request presented with start_i; only consumed in IDLE.
   always_comb begin
      size_s   = mem_size(mem_type_i);
      access_s = (size_s != SIZE_NONE);
      off_s    = addr_i[1:0];
      trap_s   = 1'b0;
`ifdef MISALIGN_TRAP_EN
      trap_s = ((size_s == SIZE_HALF) && addr_i[0]) ||
               ((size_s == SIZE_WORD) && (addr_i[1:0] != 2'b00));
`else
      if (size_s == SIZE_HALF) begin
         off_s[0] = 1'b0;
      end else if (size_s == SIZE_WORD) begin
         off_s = 2'b00;
      end
`endif
      be_s    = 4'b1111;
      wdata_s = wdata_i;
      case (size_s)
         SIZE_BYTE: begin
            be_s    = 4'b0001 << off_s;
            wdata_s = {4{wdata_i[7:0]}};
         end
         SIZE_HALF: begin
            be_s    = off_s[1] ? 4'b1100 : 4'b0011;
            wdata_s = {2{wdata_i[15:0]}};
         end
         default: ;
      endcase
   end

   assign timeout_hit = (BUS_TIMEOUT != 0) && (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      case (state_q)
         LSU_IDLE: begin
            if (start_i) begin
               state_d = (access_s && !trap_s) ? LSU_REQ : LSU_DONE;
            end
         end
         LSU_REQ: begin
            // rvalid is deliberately not looked at here, even in the gnt cycle.
            if (bus_gnt_i) begin
               state_d = we_q ? LSU_DONE : LSU_WAIT_RSP;
            end else if (timeout_hit) begin
               state_d = LSU_DONE;
            end
         end
         LSU_WAIT_RSP: begin
            if (bus_rvalid_i || timeout_hit) begin
               state_d = LSU_DONE;
            end
         end
         default: state_d = LSU_IDLE;
      endcase
   end

   // NOTE: clocked state is written with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LSU_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Wait counter restarts on every state change, so REQ and WAIT_RSP each get the full budget.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (state_d != state_q) begin
         cnt_q <= '0;
      end else if ((state_q == LSU_REQ) || (state_q == LSU_WAIT_RSP)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         size_q  <= SIZE_NONE;
         off_q   <= 2'b00;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         exc_q   <= 1'b0;
         cause_q <= '0;
      end else begin
         case (state_q)
            LSU_IDLE: begin
               if (start_i) begin
                  exc_q   <= trap_s;
                  cause_q <= !trap_s ? 32'd0 :
                             (mem_type_i[3] ? CAUSE_LOAD_MISALIGN : CAUSE_STORE_MISALIGN);
                  if (access_s && !trap_s) begin
                     size_q  <= size_s;
                     off_q   <= off_s;
                     we_q    <= ~mem_type_i[3];
                     uns_q   <= mem_type_i[0];
                     addr_q  <= addr_i[31:2];
                     be_q    <= be_s;
                     wdata_q <= wdata_s;
                  end
               end
            end
            LSU_REQ: begin
               if (!bus_gnt_i && timeout_hit) begin
                  exc_q   <= 1'b1;
                  cause_q <= we_q ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
               end
            end
            LSU_WAIT_RSP: begin
               if (bus_rvalid_i) begin
                  rdata_q <= load_data;
               end else if (timeout_hit) begin
                  exc_q   <= 1'b1;
                  cause_q <= CAUSE_LOAD_FAULT;
               end
            end
            default: ;
         endcase
      end
   end

   lsu_load_align u_load_align (
      .bus_rdata   (bus_rdata_i),
      .byte_off    (off_q),
      .size        (size_q),
      .is_unsigned (uns_q),
      .load_data   (load_data)
   );

   assign busy_o      = (state_q != LSU_IDLE);
   assign done_o      = (state_q == LSU_DONE);
   assign exc_o       = done_o & exc_q;
   assign exc_cause_o = cause_q;
   assign rdata_o     = rdata_q;
   assign bus_req_o   = (state_q == LSU_REQ);
   assign bus_we_o    = we_q;
   assign bus_addr_o  = {addr_q, 2'b00};
   assign bus_be_o    = be_q;
   assign bus_wdata_o = wdata_q;

endmodule
